// File: rtl/spw_credit_ctrl_if.sv
// Link-side signal bundle of the SpaceWire flow-control credit controller.
// master = link FSM/transceiver side, slave = credit controller.
interface spw_credit_ctrl_if;
    logic [5:0] fsm_state;
    logic       rx_got_fct;
    logic       rx_got_nchar;
    logic       tx_nchar_sent;
    logic       tx_fct_sent;
    logic [6:0] rx_fifo_free;
    logic [5:0] tx_credit;
    logic       tx_credit_ok;
    logic [5:0] rx_credit;
    logic       send_fct_req;
    logic       credit_error;

    modport master (
        output fsm_state, rx_got_fct, rx_got_nchar, tx_nchar_sent, tx_fct_sent, rx_fifo_free,
        input  tx_credit, tx_credit_ok, rx_credit, send_fct_req, credit_error
    );

    modport slave (
        input  fsm_state, rx_got_fct, rx_got_nchar, tx_nchar_sent, tx_fct_sent, rx_fifo_free,
        output tx_credit, tx_credit_ok, rx_credit, send_fct_req, credit_error
    );
endinterface

// File: rtl/spw_credit_ctrl.sv
// SpaceWire flow-control credit tracking: outgoing (tx) and incoming (rx) N-char
// credit counters, FCT request generation and credit error detection.
module spw_credit_ctrl #(
    parameter int unsigned FCT_CREDIT = 8,
    parameter int unsigned MAX_CREDIT = 56
) (
    input logic              pclk,
    input logic              reset,
    spw_credit_ctrl_if.slave bus
);

    localparam int unsigned CW = 6;
    localparam int unsigned SW = 8;
    localparam int unsigned RW = 7;
    localparam logic [5:0] ST_CONNECTING = 6'b00_1000;
    localparam logic [5:0] ST_RUN        = 6'b01_0000;

    logic [CW-1:0] tx_credit_q, tx_credit_d, tx_credit_upd;
    logic [CW-1:0] rx_credit_q, rx_credit_d, rx_credit_upd;
    logic          send_fct_req_q, send_fct_req_d;
    logic          credit_error_q, credit_error_d;
    logic          active, tx_err, rx_err;
    logic [SW-1:0] tx_sum, rx_sum;
    logic [RW-1:0] rx_next_plus;

    assign active = (bus.fsm_state == ST_CONNECTING) || (bus.fsm_state == ST_RUN);

    // Net result of a same-cycle FCT grant and single-char consume.
    assign tx_sum = SW'(tx_credit_q) + SW'(FCT_CREDIT) - SW'(bus.tx_nchar_sent);
    assign rx_sum = SW'(rx_credit_q) + SW'(FCT_CREDIT) - SW'(bus.rx_got_nchar);

    // Transmit credit: an over-limit FCT is discarded and flagged, the decrement still applies.
    always_comb begin
        tx_credit_upd = tx_credit_q;
        tx_err        = 1'b0;
        if (bus.rx_got_fct) begin
            if (tx_sum > SW'(MAX_CREDIT)) begin
                tx_err = 1'b1;
                if (bus.tx_nchar_sent) begin
                    tx_credit_upd = tx_credit_q - CW'(1);
                end
            end else begin
                tx_credit_upd = CW'(tx_sum);
            end
        end else if (bus.tx_nchar_sent && (tx_credit_q != '0)) begin
            tx_credit_upd = tx_credit_q - CW'(1);
        end
    end

    // Receive credit: an over-limit FCT send is silently dropped; N-char with no credit is an error.
    always_comb begin
        rx_credit_upd = rx_credit_q;
        rx_err        = 1'b0;
        if (bus.tx_fct_sent && (rx_sum <= SW'(MAX_CREDIT))) begin
            rx_credit_upd = CW'(rx_sum);
        end else if (bus.rx_got_nchar) begin
            if (rx_credit_q == '0) begin
                rx_err = 1'b1;
            end else begin
                rx_credit_upd = rx_credit_q - CW'(1);
            end
        end
    end

    assign rx_next_plus = RW'(rx_credit_upd) + RW'(FCT_CREDIT);

    // Next register values; everything collapses to zero outside connecting/run.
    always_comb begin
        tx_credit_d    = '0;
        rx_credit_d    = '0;
        send_fct_req_d = 1'b0;
        credit_error_d = 1'b0;
        if (active) begin
            tx_credit_d    = tx_credit_upd;
            rx_credit_d    = rx_credit_upd;
            credit_error_d = tx_err || rx_err;
            send_fct_req_d = !bus.tx_fct_sent
                          && (rx_next_plus <= RW'(MAX_CREDIT))
                          && (bus.rx_fifo_free >= rx_next_plus);
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            tx_credit_q    <= '0;
            rx_credit_q    <= '0;
            send_fct_req_q <= 1'b0;
            credit_error_q <= 1'b0;
        end else begin
            tx_credit_q    <= tx_credit_d;
            rx_credit_q    <= rx_credit_d;
            send_fct_req_q <= send_fct_req_d;
            credit_error_q <= credit_error_d;
        end
    end

    assign bus.tx_credit    = tx_credit_q;
    assign bus.tx_credit_ok = (tx_credit_q != '0);
    assign bus.rx_credit    = rx_credit_q;
    assign bus.send_fct_req = send_fct_req_q;
    assign bus.credit_error = credit_error_q;

endmodule

// File: tb/tb_spw_credit_ctrl.sv
// Self-checking bench for spw_credit_ctrl: vector table, directed corner sequences
// and randomized traffic against a behavioural credit model.
module tb_spw_credit_ctrl;

    localparam int FCT  = 8;
    localparam int MAXC = 56;
    localparam logic [5:0] S_CONN = 6'b00_1000;
    localparam logic [5:0] S_RUN  = 6'b01_0000;
    localparam logic [5:0] S_ERST = 6'b00_0000;

    typedef struct {
        logic [5:0] fsm;
        int fct, rn, ns, fs, fifo;
        int tx, rx, req, err;
    } vec_t;

    logic pclk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_tx, m_rx, m_req, m_err;

    spw_credit_ctrl_if bus();

    spw_credit_ctrl #(.FCT_CREDIT(FCT), .MAX_CREDIT(MAXC)) dut (
        .pclk (pclk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    // Reference: credits as plain integers, events applied as arithmetic rules.
    task automatic model_step();
        int t, r, e, ns, rn, grant;
        bit act;
        act = (bus.fsm_state == S_CONN) || (bus.fsm_state == S_RUN);
        if (reset || !act) begin
            m_tx = 0; m_rx = 0; m_req = 0; m_err = 0;
            return;
        end
        ns = bus.tx_nchar_sent ? 1 : 0;
        rn = bus.rx_got_nchar ? 1 : 0;
        e  = 0;
        t  = m_tx;
        if (bus.rx_got_fct) begin
            if (m_tx - ns + FCT > MAXC) begin e = 1; t = m_tx - ns; end
            else t = m_tx - ns + FCT;
        end else if (ns == 1 && m_tx > 0) begin
            t = m_tx - 1;
        end
        r = m_rx;
        grant = (bus.tx_fct_sent && (m_rx - rn + FCT <= MAXC)) ? 1 : 0;
        if (grant == 1) r = m_rx - rn + FCT;
        else if (rn == 1) begin
            if (m_rx == 0) e = 1;
            else r = m_rx - 1;
        end
        m_tx  = t;
        m_rx  = r;
        m_err = e;
        m_req = (!bus.tx_fct_sent && (r + FCT <= MAXC) && (int'(bus.rx_fifo_free) >= r + FCT)) ? 1 : 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input int tx, input int rx, input int req, input int err);
        check({name, ".tx_credit"}, int'(bus.tx_credit), tx);
        check({name, ".tx_credit_ok"}, int'(bus.tx_credit_ok), (tx != 0) ? 1 : 0);
        check({name, ".rx_credit"}, int'(bus.rx_credit), rx);
        check({name, ".send_fct_req"}, int'(bus.send_fct_req), req);
        check({name, ".credit_error"}, int'(bus.credit_error), err);
    endtask

    task automatic drive(input logic [5:0] fsm, input int fct, input int rn, input int ns,
                         input int fs, input int fifo);
        bus.fsm_state     = fsm;
        bus.rx_got_fct    = (fct != 0);
        bus.rx_got_nchar  = (rn != 0);
        bus.tx_nchar_sent = (ns != 0);
        bus.tx_fct_sent   = (fs != 0);
        bus.rx_fifo_free  = 7'(fifo);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(S_RUN, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{S_RUN,  1,0,0,0,0,  8, 0,0,0};
        tbl[1]  = '{S_RUN,  1,0,1,0,0,  15,0,0,0};
        tbl[2]  = '{S_RUN,  0,0,1,0,0,  14,0,0,0};
        tbl[3]  = '{S_RUN,  0,1,0,0,0,  14,0,0,1};
        tbl[4]  = '{S_RUN,  0,0,0,0,0,  14,0,0,0};
        tbl[5]  = '{S_RUN,  0,0,0,1,0,  14,8,0,0};
        tbl[6]  = '{S_RUN,  0,1,0,1,0,  14,15,0,0};
        tbl[7]  = '{S_RUN,  0,1,0,0,0,  14,14,0,0};
        tbl[8]  = '{S_RUN,  0,0,0,0,64, 14,14,1,0};
        tbl[9]  = '{S_RUN,  0,0,0,1,64, 14,22,0,0};
        tbl[10] = '{S_RUN,  0,0,0,0,64, 14,22,1,0};
        tbl[11] = '{S_RUN,  0,0,0,0,22, 14,22,0,0};
        tbl[12] = '{S_ERST, 1,0,1,0,0,  0, 0,0,0};
        tbl[13] = '{S_CONN, 1,0,0,0,0,  8, 0,0,0};
        tbl[14] = '{S_CONN, 0,1,1,0,64, 7, 0,1,1};
        tbl[15] = '{6'b01_1000, 1,0,0,0,0, 0,0,0,0};

        reset = 1'b1;
        drive(S_RUN, 1, 1, 1, 1, 64);
        tick();
        check_all("reset", 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].fsm, tbl[i].fct, tbl[i].rn, tbl[i].ns, tbl[i].fs, tbl[i].fifo);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].tx, tbl[i].rx, tbl[i].req, tbl[i].err);
        end

        // tx credit saturation at MAX_CREDIT
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            drive(S_RUN, 1, 0, 0, 0, 0);
            tick();
            check_all("sat_fill", 8 * i, 0, 0, 0);
        end
        drive(S_RUN, 1, 0, 0, 0, 0);
        tick();
        check_all("sat_over", 56, 0, 0, 1);
        drive(S_RUN, 0, 0, 0, 0, 0);
        tick();
        check_all("sat_after", 56, 0, 0, 0);

        // tx drain to zero and no wrap
        do_reset();
        drive(S_RUN, 1, 0, 0, 0, 0);
        tick();
        drive(S_RUN, 1, 0, 1, 0, 0);
        tick();
        check_all("drain_both", 15, 0, 0, 0);
        for (int i = 14; i >= 0; i--) begin
            drive(S_RUN, 0, 0, 1, 0, 0);
            tick();
        end
        check_all("drain_zero", 0, 0, 0, 0);
        drive(S_RUN, 0, 0, 1, 0, 0);
        tick();
        check_all("drain_under", 0, 0, 0, 0);

        // FCT request handshake in connecting state up to rx credit ceiling
        do_reset();
        drive(S_CONN, 0, 0, 0, 0, 64);
        tick();
        check_all("fct_first", 0, 0, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            drive(S_CONN, 0, 0, 0, 1, 64);
            tick();
            check_all("fct_sent", 0, 8 * k, 0, 0);
            drive(S_CONN, 0, 0, 0, 0, 64);
            tick();
            check_all("fct_rearm", 0, 8 * k, (k < 7) ? 1 : 0, 0);
        end

        // FCT request limited by RX FIFO space
        do_reset();
        drive(S_RUN, 0, 0, 0, 0, 10);
        tick();
        check_all("fifo_req", 0, 0, 1, 0);
        drive(S_RUN, 0, 0, 0, 1, 10);
        tick();
        drive(S_RUN, 0, 0, 0, 0, 10);
        tick();
        check_all("fifo_full", 0, 8, 0, 0);

        // leaving run clears counters; reset mid-run clears everything
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(S_RUN, 1, 0, 0, 0, 0); tick(); end
        for (int i = 0; i < 2; i++) begin drive(S_RUN, 0, 0, 0, 1, 0); tick(); end
        check_all("pre_exit", 24, 16, 0, 0);
        drive(S_ERST, 0, 0, 0, 0, 0);
        tick();
        check_all("exit", 0, 0, 0, 0);
        drive(S_RUN, 1, 0, 0, 0, 64);
        tick();
        drive(S_RUN, 0, 1, 0, 0, 64);
        tick();
        check_all("pre_rst", 8, 0, 1, 1);
        reset = 1'b1;
        drive(S_RUN, 1, 1, 0, 1, 64);
        tick();
        check_all("mid_rst", 0, 0, 0, 0);
        reset = 1'b0;

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] st;
            int sel;
            sel = int'($urandom_range(0, 19));
            st  = (sel < 9) ? S_RUN : (sel < 18) ? S_CONN : 6'($urandom_range(0, 63));
            reset = ($urandom_range(0, 149) == 0);
            drive(st,
                  ($urandom_range(0, 99) < 25) ? 1 : 0,
                  ($urandom_range(0, 99) < 30) ? 1 : 0,
                  ($urandom_range(0, 99) < 40) ? 1 : 0,
                  ($urandom_range(0, 99) < (bus.send_fct_req ? 60 : 10)) ? 1 : 0,
                  int'($urandom_range(0, 64)));
            tick();
            check_all("rnd", m_tx, m_rx, m_req, m_err);
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spw_credit_ctrl.md
SPW_CREDIT_CTRL -- requirements
Module: spw_credit_ctrl

Interface
REQ-001 SHALL have parameter FCT_CREDIT, default 8, meaning credit granted per FCT.
REQ-002 SHALL have parameter MAX_CREDIT, default 56, meaning maximum outstanding credit per direction.
REQ-003 SHALL have port pclk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port fsm_state, input, 6, link FSM state: connecting=6'b00_1000, run=6'b01_0000.
REQ-006 SHALL have port rx_got_fct, input, 1, one-cycle pulse: FCT received.
REQ-007 SHALL have port rx_got_nchar, input, 1, one-cycle pulse: N-char received.
REQ-008 SHALL have port tx_nchar_sent, input, 1, one-cycle pulse: transmitter sent an N-char.
REQ-009 SHALL have port tx_fct_sent, input, 1, one-cycle pulse: transmitter sent an FCT.
REQ-010 SHALL have port rx_fifo_free, input, 7, free RX FIFO slots, 0..64.
REQ-011 SHALL have port tx_credit, output, 6, N-chars the transmitter may still send.
REQ-012 SHALL have port tx_credit_ok, output, 1, high when tx_credit != 0.
REQ-013 SHALL have port rx_credit, output, 6, N-chars the far end may still send to us.
REQ-014 SHALL have port send_fct_req, output, 1, level request to the transmitter to send one FCT.
REQ-015 SHALL have port credit_error, output, 1, one-cycle pulse to the link FSM rx_credit_error input.

Function
REQ-016 SHALL define active = (fsm_state == connecting) or (fsm_state == run); all other state values are inactive.
REQ-017 SHALL, while inactive, hold tx_credit, rx_credit, send_fct_req and credit_error at 0 on every clock; all input pulses are ignored.
REQ-018 SHALL, while active, update tx_credit one cycle after the input pulses: +FCT_CREDIT on rx_got_fct; -1 on tx_nchar_sent; +(FCT_CREDIT-1) when both pulses arrive in the same cycle.
REQ-019 SHALL, when rx_got_fct would take tx_credit above MAX_CREDIT (current tx_credit > 48 after any same-cycle decrement), leave tx_credit at its decremented-only value and pulse credit_error the next cycle.
REQ-020 SHALL ignore tx_nchar_sent when tx_credit == 0 with no same-cycle rx_got_fct (no wrap to 63), and SHALL NOT raise credit_error in that case.
REQ-021 SHALL, while active, update rx_credit one cycle after the input pulses: +FCT_CREDIT on tx_fct_sent; -1 on rx_got_nchar; +(FCT_CREDIT-1) when both arrive in the same cycle.
REQ-022 SHALL, on rx_got_nchar with rx_credit == 0 and no same-cycle tx_fct_sent, leave rx_credit at 0 and pulse credit_error the next cycle.
REQ-023 SHALL ignore tx_fct_sent when it would take rx_credit above MAX_CREDIT; rx_credit stays unchanged and no error is raised.
REQ-024 SHALL register send_fct_req each cycle from post-update values: active AND (rx_credit_next + FCT_CREDIT <= MAX_CREDIT) AND (rx_fifo_free >= rx_credit_next + FCT_CREDIT), evaluated with 7-bit unsigned arithmetic.
REQ-025 SHALL force send_fct_req to 0 in the cycle after any tx_fct_sent, so one FCT is produced per request; re-evaluation resumes the cycle after that.
REQ-026 SHALL keep tx_credit_ok combinationally equal to (tx_credit != 0).
REQ-027 SHALL, when both error conditions occur in one cycle, produce a single one-cycle credit_error pulse.
REQ-028 SHALL, on a transition from active to inactive, clear all counters on the first inactive clock; any error pulse pending from the last active cycle is still issued.

Reset
REQ-029 SHALL, with reset high at a clock edge, set tx_credit=0, rx_credit=0, send_fct_req=0 and credit_error=0, giving tx_credit_ok=0; reset has priority over all other inputs.
REQ-030 SHALL, after reset deasserts, resume normal operation on the first clock edge that samples reset low.

Verification
REQ-031 SHALL cover: run state, 7 rx_got_fct pulses -> tx_credit=56, no error; 8th pulse -> tx_credit stays 56, credit_error=1 for exactly one cycle.
REQ-032 SHALL cover: run state, tx_credit=8, rx_got_fct and tx_nchar_sent in the same cycle -> tx_credit=15 next cycle; 15 further tx_nchar_sent -> tx_credit=0, tx_credit_ok=0; one more pulse -> tx_credit stays 0, no error.
REQ-033 SHALL cover: connecting state, rx_fifo_free=64, rx_credit=0 -> send_fct_req=1; tx_fct_sent -> rx_credit=8, send_fct_req=0 for one cycle, then 1 again; repeat until rx_credit=56 -> send_fct_req stays 0.
REQ-034 SHALL cover: run state, rx_fifo_free=10, rx_credit=0 -> req=1; after one FCT, rx_credit=8 -> req=0 (10 < 16).
REQ-035 SHALL cover: run state, rx_credit=0, rx_got_nchar pulse -> credit_error single pulse, rx_credit=0.
REQ-036 SHALL cover: fsm_state run -> error_reset (6'b00_0000) with tx_credit=24 and rx_credit=16 -> both counters 0 next cycle; reset asserted mid-run -> all outputs 0 on that edge.
